hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage RV32 pipeline.
//  - Adds load-use stalls, branch flush and multi-cycle data-memory wait on top of M/W forwarding.
//  - Adds a saturating stall-cycle counter.
//  - Drives stall/flush enables of pipe_fetch, pipe_decode, pipe_mem and pipe_write, plus the E-stage forwarding muxes.
// PARAMETERS
//  NUM_SRC  2   number of register source operands checked per instruction
//  REG_AW   5   register address width
//  MEM_LAT  1   data-memory latency in cycles (1 = same-cycle read, no wait)
//  CNT_W    32  width of stall_cycles counter
// PORTS
//  clk           in   1                clock, rising edge
//  rst_n         in   1                asynchronous reset, active low
//  rs_d          in   NUM_SRC*REG_AW   source regs of instruction in D (src i at [i*REG_AW+:REG_AW])
//  rs_e          in   NUM_SRC*REG_AW   source regs of instruction in E
//  rd_e          in   REG_AW           dest reg in E
//  mem_read_e    in   1                instruction in E is a load
//  take_branch_e in   1                branch/jump resolved taken in E
//  rd_m          in   REG_AW           dest reg in M
//  reg_write_m   in   1                instruction in M writes regfile
//  mem_access_m  in   1                instruction in M is a load or store
//  rd_w          in   REG_AW           dest reg in W
//  reg_write_w   in   1                instruction in W writes regfile
//  clear_stats   in   1                synchronous clear of stall_cycles
//  stall_f       out  1                hold PC
//  stall_d       out  1                hold F->D register
//  stall_e       out  1                hold D->E register
//  stall_m       out  1                hold E->M register
//  flush_d       out  1                zero F->D register
//  flush_e       out  1                zero D->E register (bubble)
//  flush_w       out  1                zero M->W register (bubble)
//  forward_e     out  NUM_SRC*2        per-source select: 00 regfile, 10 alu_result_m, 01 result_w
//  stall_cycles  out  CNT_W            count of cycles with stall_f high
// BEHAVIOUR
//  Reset (rst_n low, async): FSM=RUN, cnt=0, stall_cycles=0. Outputs forced: all stall_*=0, flush_d=flush_e=flush_w=1, forward_e=0.
//  Forwarding (combinational, per source i):
//    - rs_e[i]==0 -> 00.
//    - else reg_write_m && rd_m==rs_e[i] -> 10.
//    - else reg_write_w && rd_w==rs_e[i] -> 01.
//    - else 00. M has priority over W.
//  Memory wait FSM (states RUN, WAIT; down-counter cnt, width clog2(MEM_LAT)+1):
//    - RUN: if mem_access_m && MEM_LAT>1 -> mem_stall=1 this cycle; next WAIT, cnt=MEM_LAT-2.
//    - WAIT: cnt!=0 -> mem_stall=1, cnt--. cnt==0 -> mem_stall=0, next RUN.
//    - Total mem_stall per access = MEM_LAT-1 cycles. MEM_LAT=1: FSM never leaves RUN.
//    - Back-to-back accesses: the next access is detected in RUN on the cycle after WAIT exits.
//    - mem_stall=1 -> stall_f/d/e/m=1, flush_w=1; flush_d/flush_e suppressed.
//  Load-use:
//    - lu = mem_read_e && rd_e!=0 && rd_e equals any rs_d[i].
//    - lu && !take_branch_e && !mem_stall -> stall_f=stall_d=1, flush_e=1, for exactly one cycle.
//  Branch:
//    - take_branch_e && !mem_stall -> flush_d=flush_e=1, stall_f=0.
//    - Overrides load-use.
//    - During mem_stall E is frozen, so the branch is held and flushes on the first non-stall cycle.
//  Priority: reset > mem_stall > branch > load-use > run.
//  stall_cycles:
//    - +1 on each cycle with stall_f=1; saturates at all ones.
//    - clear_stats sets it to 0 next edge; clear wins over increment.
// STRUCTURE
//  - hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10) and hz_state_t enum (RUN, WAIT).
//  - Sub-module fwd_sel: one source-vs-M/W comparator, generated NUM_SRC times.
//  - FSM, counter and stall/flush priority logic live in hazard_ctrl.
// TESTING
//  1. rs_e[0]=5, rd_m=5/reg_write_m=1, rd_w=5/reg_write_w=1 -> forward_e[1:0]=10; clear reg_write_m -> 01; rs_e[0]=0 -> 00.
//  2. mem_read_e=1, rd_e=7, rs_d[1]=7 -> one cycle of stall_f=stall_d=flush_e=1, then released; rd_e=0 -> no stall.
//  3. MEM_LAT=3, mem_access_m pulse -> stall_f/d/e/m=flush_w=1 for exactly 2 cycles, stall_cycles +2.
//  4. MEM_LAT=3, take_branch_e=1 during wait -> flush_d=flush_e=0 while stalled, =1 on the first free cycle.
//  5. Load-use and take_branch_e together -> flush_d=flush_e=1, stall_f=0.
//  6. Async rst_n low mid-WAIT -> stalls drop immediately, flushes=1, FSM in RUN, stall_cycles=0.
//     Counter check: force 2^CNT_W-1 -> stays saturated; clear_stats -> 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: forwarding mux selects and memory-wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard inputs from the stages, stall/flush/forward controls back.
interface hazard_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32
);
  logic [NUM_SRC*REG_AW-1:0] rs_d;
  logic [NUM_SRC*REG_AW-1:0] rs_e;
  logic [REG_AW-1:0]         rd_e;
  logic                      mem_read_e;
  logic                      take_branch_e;
  logic [REG_AW-1:0]         rd_m;
  logic                      reg_write_m;
  logic                      mem_access_m;
  logic [REG_AW-1:0]         rd_w;
  logic                      reg_write_w;
  logic                      clear_stats;
  logic                      stall_f;
  logic                      stall_d;
  logic                      stall_e;
  logic                      stall_m;
  logic                      flush_d;
  logic                      flush_e;
  logic                      flush_w;
  logic [NUM_SRC*2-1:0]      forward_e;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output rs_d, rs_e, rd_e, mem_read_e, take_branch_e, rd_m, reg_write_m,
           mem_access_m, rd_w, reg_write_w, clear_stats,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           forward_e, stall_cycles
  );

  modport slave (
    input  rs_d, rs_e, rd_e, mem_read_e, take_branch_e, rd_m, reg_write_m,
           mem_access_m, rd_w, reg_write_w, clear_stats,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           forward_e, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one E-stage source operand; M result has priority over W, x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  output fwd_sel_t          sel_o
);

  // source-vs-producer compare with M-before-W priority
  always_comb begin
    sel_o = FWD_RF;
    if (!(|rs_i)) begin
      sel_o = FWD_RF;
    end else if (reg_write_m_i && (rd_m_i == rs_i)) begin
      sel_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i == rs_i)) begin
      sel_o = FWD_W;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: M/W forwarding, load-use stall, branch flush, multi-cycle memory wait
// and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam int            CW       = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 2);
  localparam logic          MULTI    = (MEM_LAT > 1) ? 1'b1 : 1'b0;

  hz_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lu_q, lu_d;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             mem_stall_s;
  logic             lu_s;
  logic             stall_f_s;
  fwd_sel_t         fwd_s [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
      .rs_i          (hz.rs_e[i*REG_AW +: REG_AW]),
      .rd_m_i        (hz.rd_m),
      .reg_write_m_i (hz.reg_write_m),
      .rd_w_i        (hz.rd_w),
      .reg_write_w_i (hz.reg_write_w),
      .sel_o         (fwd_s[i])
    );
  end

  // forwarding selects, forced to regfile while in reset
  always_comb begin
    hz.forward_e = {(NUM_SRC*2){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst_n) begin
        hz.forward_e[i*2 +: 2] = fwd_s[i];
      end else begin
        hz.forward_e[i*2 +: 2] = FWD_RF;
      end
    end
  end

  // load in E whose destination feeds any D source
  always_comb begin
    lu_s = 1'b0;
    if (hz.mem_read_e && (|hz.rd_e)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hz.rs_d[i*REG_AW +: REG_AW] == hz.rd_e) begin
          lu_s = 1'b1;
        end else begin
          lu_s = lu_s;
        end
      end
    end else begin
      lu_s = 1'b0;
    end
  end

  // memory-wait FSM; cnt holds the stall cycles still owed after the current one
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_stall_s = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.mem_access_m && MULTI) begin
          mem_stall_s = 1'b1;
          state_d     = WAIT;
          cnt_d       = CNT_INIT;
        end else begin
          state_d = RUN;
        end
      end
      WAIT: begin
        if (cnt_q != {CW{1'b0}}) begin
          mem_stall_s = 1'b1;
          cnt_d       = cnt_q - CW'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // stall/flush priority: reset > mem wait > branch > load-use; lu_q keeps a load-use stall to one cycle
  always_comb begin
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.stall_e = 1'b0;
    hz.stall_m = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.flush_w = 1'b0;
    lu_d       = 1'b0;
    if (!rst_n) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
      hz.flush_w = 1'b1;
    end else if (mem_stall_s) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.stall_e = 1'b1;
      hz.stall_m = 1'b1;
      hz.flush_w = 1'b1;
    end else if (hz.take_branch_e) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
    end else if (lu_s && !lu_q) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.flush_e = 1'b1;
      lu_d       = 1'b1;
    end else begin
      lu_d = 1'b0;
    end
  end

  assign stall_f_s       = hz.stall_f;
  assign hz.stall_cycles = stall_cycles_q;

  // FSM and load-use history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= {CW{1'b0}};
      lu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lu_q    <= lu_d;
    end
  end

  // saturating stall-cycle counter, clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= {CNT_W{1'b0}};
    end else if (hz.clear_stats) begin
      stall_cycles_q <= {CNT_W{1'b0}};
    end else if (stall_f_s && !(&stall_cycles_q)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_q <= stall_cycles_q;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // model state: cycles left in the current memory window (stall cycles + exit cycle)
  int   win;
  bit   lu_prev;
  int   sat_cnt;

  hazard_ctrl_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .CNT_W(CNT_W)) tb_if ();

  hazard_ctrl #(
    .NUM_SRC (NUM_SRC),
    .REG_AW  (REG_AW),
    .MEM_LAT (MEM_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (tb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_vec();
    return {tb_if.stall_f, tb_if.stall_d, tb_if.stall_e, tb_if.stall_m,
            tb_if.flush_d, tb_if.flush_e, tb_if.flush_w};
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (tb_if.reg_write_m && tb_if.rd_m == rs) return 2'b10;
    if (tb_if.reg_write_w && tb_if.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Called just after a negedge with inputs set: checks outputs, then advances one clock.
  task automatic cycle(input string tag);
    int         w;
    bit         ms, ld, br, lus;
    logic [6:0] exp_ctl;
    logic [3:0] exp_fwd;
    #2;
    w = win;
    if (w == 0 && tb_if.mem_access_m && MEM_LAT > 1) w = MEM_LAT;
    ms  = (w >= 2);
    ld  = tb_if.mem_read_e && (tb_if.rd_e != 0) &&
          (tb_if.rd_e == tb_if.rs_d[4:0] || tb_if.rd_e == tb_if.rs_d[9:5]);
    br  = tb_if.take_branch_e && !ms;
    lus = ld && !tb_if.take_branch_e && !ms && !lu_prev;
    if (ms)       exp_ctl = 7'b1111001;
    else if (br)  exp_ctl = 7'b0000110;
    else if (lus) exp_ctl = 7'b1100010;
    else          exp_ctl = 7'b0000000;
    exp_fwd = {ref_fwd(tb_if.rs_e[9:5]), ref_fwd(tb_if.rs_e[4:0])};
    expect_eq({tag, "_ctl"}, 32'(ctl_vec()), 32'(exp_ctl));
    expect_eq({tag, "_fwd"}, 32'(tb_if.forward_e), 32'(exp_fwd));
    expect_eq({tag, "_cnt"}, 32'(tb_if.stall_cycles), 32'(sat_cnt));
    @(posedge clk);
    win     = (w > 0) ? w - 1 : 0;
    lu_prev = lus;
    if (tb_if.clear_stats) sat_cnt = 0;
    else if (exp_ctl[6] && sat_cnt < CNT_MAX) sat_cnt = sat_cnt + 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    tb_if.rs_d = 10'd0; tb_if.rs_e = 10'd0; tb_if.rd_e = 5'd0;
    tb_if.mem_read_e = 1'b0; tb_if.take_branch_e = 1'b0;
    tb_if.rd_m = 5'd0; tb_if.reg_write_m = 1'b0; tb_if.mem_access_m = 1'b0;
    tb_if.rd_w = 5'd0; tb_if.reg_write_w = 1'b0; tb_if.clear_stats = 1'b0;
  endtask

  initial begin
    int base;
    checks = 0; errors = 0;
    win = 0; lu_prev = 1'b0; sat_cnt = 0;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    expect_eq("reset_ctl", 32'(ctl_vec()), 32'(7'b0000111));
    expect_eq("reset_fwd", 32'(tb_if.forward_e), 32'd0);
    expect_eq("reset_cnt", 32'(tb_if.stall_cycles), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cycle("idle");

    // forwarding priority M > W, x0 never forwarded
    tb_if.rs_e = {5'd0, 5'd5}; tb_if.rd_m = 5'd5; tb_if.reg_write_m = 1'b1;
    tb_if.rd_w = 5'd5; tb_if.reg_write_w = 1'b1;
    #1 expect_eq("fwd_m", 32'(tb_if.forward_e[1:0]), 32'(2'b10));
    cycle("fwd_m");
    tb_if.reg_write_m = 1'b0;
    #1 expect_eq("fwd_w", 32'(tb_if.forward_e[1:0]), 32'(2'b01));
    cycle("fwd_w");
    tb_if.rs_e = 10'd0;
    #1 expect_eq("fwd_x0", 32'(tb_if.forward_e[1:0]), 32'(2'b00));
    cycle("fwd_x0");
    idle_inputs();

    // load-use: one stall cycle even if the hazard is still presented
    tb_if.mem_read_e = 1'b1; tb_if.rd_e = 5'd7; tb_if.rs_d = {5'd7, 5'd3};
    #1 expect_eq("lu_stall", 32'(ctl_vec()), 32'(7'b1100010));
    cycle("lu1");
    cycle("lu2");
    tb_if.mem_read_e = 1'b0;
    cycle("lu_rel");
    tb_if.mem_read_e = 1'b1; tb_if.rd_e = 5'd0; tb_if.rs_d = 10'd0;
    cycle("lu_x0");
    idle_inputs();
    cycle("gap");

    // memory wait: two stall cycles, counter +2
    base = sat_cnt;
    tb_if.mem_access_m = 1'b1;
    cycle("mem1");
    tb_if.mem_access_m = 1'b0;
    cycle("mem2");
    cycle("mem3");
    expect_eq("mem_cnt", 32'(tb_if.stall_cycles), 32'(base + 2));
    cycle("mem4");

    // branch held across memory wait
    tb_if.mem_access_m = 1'b1; tb_if.take_branch_e = 1'b1;
    cycle("brw1");
    tb_if.mem_access_m = 1'b0;
    cycle("brw2");
    #1 expect_eq("brw_free", 32'(ctl_vec()), 32'(7'b0000110));
    cycle("brw3");

    // branch overrides load-use
    tb_if.mem_read_e = 1'b1; tb_if.rd_e = 5'd9; tb_if.rs_d = {5'd1, 5'd9};
    #1 expect_eq("br_lu", 32'(ctl_vec()), 32'(7'b0000110));
    cycle("br_lu");
    idle_inputs();
    cycle("gap2");

    // async reset mid-wait
    tb_if.mem_access_m = 1'b1;
    cycle("rw1");
    tb_if.mem_access_m = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    expect_eq("arst_ctl", 32'(ctl_vec()), 32'(7'b0000111));
    expect_eq("arst_cnt", 32'(tb_if.stall_cycles), 32'd0);
    win = 0; lu_prev = 1'b0; sat_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("after_rst");

    // saturation and clear
    tb_if.mem_access_m = 1'b1;
    for (int i = 0; i < 30; i++) cycle("sat");
    tb_if.mem_access_m = 1'b0;
    cycle("sat_drain");
    cycle("sat_drain2");
    expect_eq("sat_max", 32'(tb_if.stall_cycles), 32'(CNT_MAX));
    tb_if.clear_stats = 1'b1;
    tb_if.mem_access_m = 1'b1;
    cycle("clr");
    tb_if.clear_stats = 1'b0;
    tb_if.mem_access_m = 1'b0;
    #1 expect_eq("clr_zero", 32'(tb_if.stall_cycles), 32'd0);
    cycle("clr2");
    cycle("clr3");

    // randomized traffic with a small register pool to provoke matches
    for (int n = 0; n < 400; n++) begin
      tb_if.rs_d          = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      tb_if.rs_e          = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      tb_if.rd_e          = 5'($urandom_range(0, 3));
      tb_if.mem_read_e    = 1'($urandom_range(0, 1));
      tb_if.take_branch_e = ($urandom_range(0, 4) == 0);
      tb_if.rd_m          = 5'($urandom_range(0, 3));
      tb_if.reg_write_m   = 1'($urandom_range(0, 1));
      tb_if.mem_access_m  = ($urandom_range(0, 5) == 0);
      tb_if.rd_w          = 5'($urandom_range(0, 3));
      tb_if.reg_write_w   = 1'($urandom_range(0, 1));
      tb_if.clear_stats   = ($urandom_range(0, 19) == 0);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
